// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// Holds the loader state encoding, frame constants and the checksum step.
package prog_loader_pkg;

    localparam int         WORD_W       = 32;
    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_CSUM   = 3'd5,
        ST_DONE   = 3'd6,
        ST_ERR    = 3'd7
    } state_t;

    function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/prog_loader_word_assembler.sv
// Big-endian byte-to-word assembler with a 2-bit byte counter and running XOR checksum.
// The presented word combines the three buffered bytes with the byte currently on din.
module word_assembler
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              en,
    input  logic [7:0]        din,
    output logic [1:0]        cnt,
    output logic [WORD_W-1:0] word,
    output logic [7:0]        csum
);

    logic [WORD_W-9:0] shift_r;
    logic [1:0]        cnt_r;
    logic [7:0]        csum_r;

    // Byte shift register, byte counter and checksum accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= '0;
            cnt_r   <= 2'd0;
            csum_r  <= 8'h00;
        end else if (clr) begin
            shift_r <= '0;
            cnt_r   <= 2'd0;
            csum_r  <= 8'h00;
        end else if (en) begin
            shift_r <= {shift_r[WORD_W-17:0], din};
            cnt_r   <= cnt_r + 2'd1;
            csum_r  <= csum_step(csum_r, din);
        end else begin
            shift_r <= shift_r;
            cnt_r   <= cnt_r;
            csum_r  <= csum_r;
        end
    end

    assign cnt  = cnt_r;
    assign word = {shift_r, din};
    assign csum = csum_r;

endmodule

// File: rtl/prog_loader.sv
// Boot loader: parses SYNC/LEN/data/checksum frames from a byte link and writes
// the image into word memory while holding the core halted.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int         AW        = 10,
    parameter int         BASE_ADDR = 0,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic          rx_ready,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic          mem_wr_ready,
    output logic          core_hold,
    output logic          load_done,
    output logic          load_err
);

    localparam logic [AW-1:0] BASE_A    = AW'(BASE_ADDR);
    localparam logic [16:0]   MAX_WORDS = 17'((1 << AW) - BASE_ADDR);

    state_t            state_r, state_nx;
    logic              rx_ready_r, rx_ready_nx;
    logic              mem_we_r, mem_we_nx;
    logic [AW-1:0]     mem_addr_r, mem_addr_nx;
    logic [31:0]       mem_wdata_r, mem_wdata_nx;
    logic              core_hold_r, core_hold_nx;
    logic              load_done_r, load_done_nx;
    logic              load_err_r, load_err_nx;
    logic [15:0]       len_r, len_nx;
    logic [15:0]       wcnt_r, wcnt_nx;

    logic              acc_s, asm_clr_s, asm_en_s, sync_s;
    logic [15:0]       len_new_s, wcnt_inc_s;
    logic [1:0]        asm_cnt_s;
    logic [WORD_W-1:0] asm_word_s;
    logic [7:0]        asm_csum_s;

    assign acc_s      = rx_valid & rx_ready_r;
    assign sync_s     = acc_s & (rx_data == SYNC_BYTE);
    assign len_new_s  = {len_r[15:8], rx_data};
    assign wcnt_inc_s = wcnt_r + 16'd1;

    word_assembler u_asm (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (asm_clr_s),
        .en    (asm_en_s),
        .din   (rx_data),
        .cnt   (asm_cnt_s),
        .word  (asm_word_s),
        .csum  (asm_csum_s)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            rx_ready_r  <= 1'b1;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= BASE_A;
            mem_wdata_r <= 32'h0000_0000;
            core_hold_r <= 1'b1;
            load_done_r <= 1'b0;
            load_err_r  <= 1'b0;
            len_r       <= 16'd0;
            wcnt_r      <= 16'd0;
        end else begin
            state_r     <= state_nx;
            rx_ready_r  <= rx_ready_nx;
            mem_we_r    <= mem_we_nx;
            mem_addr_r  <= mem_addr_nx;
            mem_wdata_r <= mem_wdata_nx;
            core_hold_r <= core_hold_nx;
            load_done_r <= load_done_nx;
            load_err_r  <= load_err_nx;
            len_r       <= len_nx;
            wcnt_r      <= wcnt_nx;
        end
    end

    // Frame parser: next state and next register values.
    always_comb begin
        state_nx     = state_r;
        rx_ready_nx  = rx_ready_r;
        mem_we_nx    = mem_we_r;
        mem_addr_nx  = mem_addr_r;
        mem_wdata_nx = mem_wdata_r;
        core_hold_nx = core_hold_r;
        load_done_nx = load_done_r;
        load_err_nx  = load_err_r;
        len_nx       = len_r;
        wcnt_nx      = wcnt_r;
        asm_clr_s    = 1'b0;
        asm_en_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (sync_s) begin
                    state_nx  = ST_LEN_HI;
                    asm_clr_s = 1'b1;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_LEN_HI: begin
                if (acc_s) begin
                    len_nx   = {rx_data, 8'h00};
                    state_nx = ST_LEN_LO;
                end else begin
                    state_nx = ST_LEN_HI;
                end
            end
            ST_LEN_LO: begin
                if (acc_s) begin
                    len_nx  = len_new_s;
                    wcnt_nx = 16'd0;
                    if ({1'b0, len_new_s} > MAX_WORDS) begin
                        state_nx    = ST_ERR;
                        load_err_nx = 1'b1;
                    end else if (len_new_s == 16'd0) begin
                        state_nx = ST_CSUM;
                    end else begin
                        state_nx = ST_DATA;
                    end
                end else begin
                    state_nx = ST_LEN_LO;
                end
            end
            ST_DATA: begin
                if (acc_s) begin
                    asm_en_s = 1'b1;
                    if (asm_cnt_s == 2'd3) begin
                        state_nx     = ST_WRITE;
                        mem_we_nx    = 1'b1;
                        rx_ready_nx  = 1'b0;
                        mem_wdata_nx = asm_word_s;
                    end else begin
                        state_nx = ST_DATA;
                    end
                end else begin
                    state_nx = ST_DATA;
                end
            end
            ST_WRITE: begin
                if (mem_wr_ready) begin
                    mem_we_nx   = 1'b0;
                    rx_ready_nx = 1'b1;
                    mem_addr_nx = mem_addr_r + {{(AW-1){1'b0}}, 1'b1};
                    wcnt_nx     = wcnt_inc_s;
                    if (wcnt_inc_s == len_r) begin
                        state_nx = ST_CSUM;
                    end else begin
                        state_nx = ST_DATA;
                    end
                end else begin
                    state_nx = ST_WRITE;
                end
            end
            ST_CSUM: begin
                if (acc_s) begin
                    if (rx_data == asm_csum_s) begin
                        state_nx     = ST_DONE;
                        load_done_nx = 1'b1;
                        core_hold_nx = 1'b0;
                    end else begin
                        state_nx    = ST_ERR;
                        load_err_nx = 1'b1;
                    end
                end else begin
                    state_nx = ST_CSUM;
                end
            end
            ST_DONE, ST_ERR: begin
                // A new SYNC restarts the load from the base address.
                if (sync_s) begin
                    state_nx     = ST_LEN_HI;
                    core_hold_nx = 1'b1;
                    load_done_nx = 1'b0;
                    load_err_nx  = 1'b0;
                    mem_addr_nx  = BASE_A;
                    asm_clr_s    = 1'b1;
                end else begin
                    state_nx = state_r;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign rx_ready  = rx_ready_r;
    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign core_hold = core_hold_r;
    assign load_done = load_done_r;
    assign load_err  = load_err_r;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader with a frame-level reference model.
module tb_prog_loader;

    localparam int AW   = 10;
    localparam int MAXW = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          mem_wr_ready;
    logic          core_hold;
    logic          load_done;
    logic          load_err;

    prog_loader #(.AW(AW), .BASE_ADDR(0), .SYNC_BYTE(8'hA5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wr_ready (mem_wr_ready),
        .core_hold    (core_hold),
        .load_done    (load_done),
        .load_err     (load_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int          rmode  = 0;
    int          gaps   = 0;
    int          exp_we_len = 0;

    // reference model state
    bit          m_active;
    int          m_k, m_n;
    logic [7:0]  m_csum;
    logic [31:0] m_word;
    bit          exp_done, exp_err;
    int          exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          log_addr[$];
    logic [31:0] log_data[$];

    bit          prev_stall;
    logic [AW-1:0] prev_addr;
    logic [31:0] prev_data;
    int          we_len;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task model_reset();
        m_active = 0; m_k = 0; m_n = 0; m_csum = 8'h00; m_word = 32'h0;
        exp_done = 0; exp_err = 0;
        exp_addr_q.delete(); exp_data_q.delete();
        prev_stall = 0; we_len = 0;
    endtask

    task model_accept(input logic [7:0] b);
        if (!m_active) begin
            if (b == 8'hA5) begin
                m_active = 1; m_k = 0; m_csum = 8'h00;
                exp_done = 0; exp_err = 0;
            end
        end else begin
            m_k++;
            if (m_k == 1) begin
                m_n = int'(b) * 256;
            end else if (m_k == 2) begin
                m_n = m_n + int'(b);
                if (m_n > MAXW) begin
                    exp_err = 1; m_active = 0;
                end
            end else if (m_k < 3 + 4 * m_n) begin
                m_word = {m_word[23:0], b};
                m_csum = m_csum ^ b;
                if ((m_k - 3) % 4 == 3) begin
                    exp_addr_q.push_back((m_k - 3) / 4);
                    exp_data_q.push_back(m_word);
                end
            end else begin
                if (b == m_csum) exp_done = 1;
                else exp_err = 1;
                m_active = 0;
            end
        end
    endtask

    // per-cycle comparison against the model, sampled away from the active edge
    always @(negedge clk) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            chk("load_done", load_done, exp_done);
            chk("load_err", load_err, exp_err);
            chk("core_hold", core_hold, !exp_done);
            chk("rx_ready_vs_we", rx_ready, !mem_we);
            if (prev_stall) begin
                chk("we_held", mem_we, 1'b1);
                chk("addr_held", mem_addr, prev_addr);
                chk("data_held", mem_wdata, prev_data);
            end
            if (mem_we) we_len++;
            if (mem_we && mem_wr_ready) begin
                if (exp_addr_q.size() == 0) begin
                    chk("unexpected_write", 1'b1, 1'b0);
                end else begin
                    chk("wr_addr", mem_addr, exp_addr_q.pop_front());
                    chk("wr_data", mem_wdata, exp_data_q.pop_front());
                end
                if (exp_we_len != 0) chk("we_cycles", we_len, exp_we_len);
                log_addr.push_back(int'(mem_addr));
                log_data.push_back(mem_wdata);
                we_len = 0;
            end
            prev_stall = mem_we && !mem_wr_ready;
            prev_addr  = mem_addr;
            prev_data  = mem_wdata;
            if (rx_valid && rx_ready) model_accept(rx_data);
        end
    end

    // memory-side ready generator: 0 always ready, 1 three-cycle stall, 2 random
    initial begin
        int st;
        st = 0;
        mem_wr_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                0: mem_wr_ready = 1'b1;
                1: begin
                    if (mem_we) begin
                        mem_wr_ready = (st >= 3);
                        st++;
                    end else begin
                        st = 0;
                        mem_wr_ready = 1'b0;
                    end
                end
                default: mem_wr_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send(input logic [7:0] b);
        bit acc;
        if (gaps != 0) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        rx_data = b; rx_valid = 1'b1; acc = 0;
        for (int t = 0; t < 100 && !acc; t++) begin
            @(negedge clk);
            acc = rx_ready;
        end
        if (!acc) chk("rx_timeout", acc, 1'b1);
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_nominal(input logic [7:0] last);
        logic [7:0] f [12];
        f = '{8'hA5, 8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h0A, 8'h18, 8'h00, 8'h00, 8'h00, 8'h37};
        f[11] = last;
        foreach (f[i]) send(f[i]);
    endtask

    task automatic settle();
        repeat (3) begin @(posedge clk); #1; end
    endtask

    initial begin
        int n0, nw;
        logic [7:0] cs, bt;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        #12;
        chk("rst_rx_ready", rx_ready, 1'b1);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", mem_addr, 10'd0);
        chk("rst_core_hold", core_hold, 1'b1);
        chk("rst_load_done", load_done, 1'b0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;

        // nominal load
        rmode = 0; exp_we_len = 1; n0 = log_addr.size();
        send_nominal(8'h37); settle();
        chk("nom_done", load_done, 1'b1);
        chk("nom_hold", core_hold, 1'b0);
        chk("nom_err", load_err, 1'b0);
        chk("nom_nwrites", log_addr.size() - n0, 2);
        if (log_addr.size() - n0 == 2) begin
            chk("nom_a0", log_addr[n0], 0);
            chk("nom_d0", log_data[n0], 32'h2401000A);
            chk("nom_a1", log_addr[n0+1], 1);
            chk("nom_d1", log_data[n0+1], 32'h18000000);
        end

        // backpressure reload
        rmode = 1; exp_we_len = 4; n0 = log_addr.size();
        send_nominal(8'h37); settle();
        chk("bp_done", load_done, 1'b1);
        chk("bp_nwrites", log_addr.size() - n0, 2);

        // bad checksum
        rmode = 0; exp_we_len = 1; n0 = log_addr.size();
        send_nominal(8'h36); settle();
        chk("bad_err", load_err, 1'b1);
        chk("bad_hold", core_hold, 1'b1);
        chk("bad_done", load_done, 1'b0);
        chk("bad_nwrites", log_addr.size() - n0, 2);

        // overflow length
        n0 = log_addr.size();
        send(8'hA5); send(8'h04); send(8'h01); settle();
        chk("ovf_err", load_err, 1'b1);
        chk("ovf_nwrites", log_addr.size() - n0, 0);

        // zero length, then garbage and reload
        send(8'hA5); send(8'h00); send(8'h00); send(8'h00); settle();
        chk("zero_done", load_done, 1'b1);
        chk("zero_nwrites", log_addr.size() - n0, 0);
        send(8'h11); send(8'h22);
        send_nominal(8'h37); settle();
        chk("reload_done", load_done, 1'b1);
        chk("reload_a0", log_addr[log_addr.size()-2], 0);

        // async reset mid-DATA
        send(8'hA5); send(8'h00); send(8'h02); send(8'h24); send(8'h01);
        #2; rst_n = 1'b0; #1;
        chk("arst_rx_ready", rx_ready, 1'b1);
        chk("arst_mem_we", mem_we, 1'b0);
        chk("arst_mem_addr", mem_addr, 10'd0);
        chk("arst_wdata", mem_wdata, 32'h0);
        chk("arst_hold", core_hold, 1'b1);
        chk("arst_done", load_done, 1'b0);
        chk("arst_err", load_err, 1'b0);
        repeat (2) @(posedge clk); #1; rst_n = 1'b1;
        @(posedge clk); #1;
        send_nominal(8'h37); settle();
        chk("arst_reload_done", load_done, 1'b1);

        // randomized frames
        gaps = 1;
        for (int f = 0; f < 8; f++) begin
            rmode = $urandom_range(0, 2);
            exp_we_len = (rmode == 0) ? 1 : (rmode == 1) ? 4 : 0;
            repeat ($urandom_range(0, 2)) begin
                bt = 8'($urandom_range(0, 255));
                if (bt == 8'hA5) bt = 8'h5A;
                send(bt);
            end
            nw = $urandom_range(1, 5);
            cs = 8'h00;
            send(8'hA5); send(8'h00); send(8'(nw));
            for (int i = 0; i < 4 * nw; i++) begin
                bt = 8'($urandom_range(0, 255));
                cs = cs ^ bt;
                send(bt);
            end
            send(($urandom_range(0, 3) == 0) ? ~cs : cs);
            settle();
        end
        chk("exp_queue_empty", exp_addr_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
